// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the GEMM operand FIFO reader: FSM states and the
// default tile length that the FIFO writer and reader must agree on.
package buffer_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } reader_state_e;

    localparam int TILE_LEN_DEFAULT = 8;

endpackage

// File: rtl/reader_out_stage.sv
// Output register for the reader: data, last, tile index and valid.
// Latency: one cycle from load to valid output.
// Backpressure: holds every field while out_valid && !out_ready; a load replaces the element in the same edge as an accept.
module reader_out_stage #(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    input  logic [CNT_W-1:0]  load_tile,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [CNT_W-1:0]  tile_idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            tile_idx  <= '0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
            tile_idx  <= load_tile;
        end else if (out_valid && out_ready) begin
            // Payload fields keep their last value; only valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/buffer_reader.sv
// Pops a show-ahead operand FIFO and streams num_tiles*TILE_LEN elements, framed per tile.
// Latency: start -> first pop 1 cycle -> out_valid 2 cycles; one element/cycle sustained.
// Backpressure: no pop while out_valid && !out_ready. Optional BUFFER_READER_STALL_CNT_EN adds stall_cnt.
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int TILE_LEN = TILE_LEN_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_tiles,
    output logic              busy,
    output logic              done,
`ifdef BUFFER_READER_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  tile_idx
);

    localparam int EW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam logic [EW-1:0] ELEM_LAST = EW'(TILE_LEN - 1);

    reader_state_e    state, state_nxt;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] tile_cnt;
    logic [EW-1:0]    elem_cnt;
    logic             start_acc;
    logic             pop;
    logic             elem_wrap;
    logic             final_pop;

    assign start_acc  = (state == IDLE) && start;
    assign pop        = (state == RUN) && !fifo_empty && (!out_valid || out_ready);
    assign elem_wrap  = (elem_cnt == ELEM_LAST);
    assign final_pop  = pop && elem_wrap && (tile_cnt == (num_q - CNT_W'(1)));
    assign fifo_rd_en = pop;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_tiles == '0) ? DONE : RUN;
            RUN:   if (final_pop) state_nxt = FLUSH;
            FLUSH: if (out_valid && out_ready) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q    <= '0;
            tile_cnt <= '0;
            elem_cnt <= '0;
        end else if (start_acc) begin
            num_q    <= num_tiles;
            tile_cnt <= '0;
            elem_cnt <= '0;
        end else if (pop) begin
            if (elem_wrap) begin
                elem_cnt <= '0;
                tile_cnt <= tile_cnt + CNT_W'(1);
            end else begin
                elem_cnt <= elem_cnt + EW'(1);
            end
        end
    end

    reader_out_stage #(
        .DWIDTH (DWIDTH),
        .CNT_W  (CNT_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .load_data (fifo_dout),
        .load_last (elem_wrap),
        .load_tile (tile_cnt),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .tile_idx  (tile_idx)
    );

`ifdef BUFFER_READER_STALL_CNT_EN
    // Starved: the output slot could take an element but the FIFO has none.
    logic starve;
    assign starve = (state == RUN) && fifo_empty && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (starve && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench for buffer_reader with a show-ahead FIFO model driven by the bench.
module tb_buffer_reader;
    import buffer_reader_pkg::*;

    localparam int DW = 16;
    localparam int TL = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_tiles = '0;
    logic          busy, done, fifo_empty, fifo_rd_en, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [DW-1:0] fifo_dout, out_data;
    logic [CW-1:0] tile_idx;
`ifdef BUFFER_READER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    buffer_reader #(.DWIDTH(DW), .TILE_LEN(TL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_tiles  (num_tiles),
        .busy       (busy),
        .done       (done),
`ifdef BUFFER_READER_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .tile_idx   (tile_idx)
    );

    always #5 clk = ~clk;

    // FIFO model: element at index i holds value i+1
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr[7:0]];

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [CW-1:0] t;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_next = 1;
    int run_accepts = 0;
    int run_pops = 0;
    int run_total = 0;
    int first_acc_cyc = 0;
    int last_acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int model_stall = 0;
    int start_cyc = 0;
    bit rd_seen = 0;
    bit bp_mode = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic [CW-1:0] prev_t;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !rst) begin
            rd_ptr   <= rd_ptr + 1;
            run_pops <= run_pops + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = ~out_ready;
    end

    // Monitor: scoreboard compare on every accepted beat plus protocol checks
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            exp_t e;
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                failures++;
                $display("FAIL rd_en_while_empty cyc=%0d rd_en=%b required=0", cyc, fifo_rd_en);
            end
            checks++;
            if (fifo_rd_en && out_valid && !out_ready) begin
                failures++;
                $display("FAIL rd_en_during_stall cyc=%0d rd_en=%b required=0", cyc, fifo_rd_en);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l || tile_idx !== prev_t) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got v=%b d=%0d l=%b t=%0d required v=1 d=%0d l=%b t=%0d",
                             cyc, out_valid, out_data, out_last, tile_idx, prev_d, prev_l, prev_t);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat cyc=%0d data=%0d required=no beat", cyc, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_last !== e.l || tile_idx !== e.t) begin
                        failures++;
                        $display("FAIL beat cyc=%0d got d=%0d l=%b t=%0d required d=%0d l=%b t=%0d",
                                 cyc, out_data, out_last, tile_idx, e.d, e.l, e.t);
                    end
                end
                run_accepts++;
                if (run_accepts == 1) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
            if (busy && run_pops < run_total && fifo_empty && (!out_valid || out_ready))
                model_stall++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fifo_rd_en) rd_seen = 1;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            prev_t = tile_idx;
        end
    end

    task automatic fifo_write(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = DW'(wr_ptr + 1);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_start(input int n);
        for (int i = 0; i < n * TL; i++) begin
            exp_t e;
            e.d = DW'(exp_next);
            e.l = ((i % TL) == TL - 1);
            e.t = CW'(i / TL);
            sb.push_back(e);
            exp_next++;
        end
        run_accepts = 0;
        run_pops    = 0;
        run_total   = n * TL;
        @(negedge clk); #1;
        start     = 1'b1;
        num_tiles = CW'(n);
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout done_cnt=%0d required>%0d", name, done_cnt, d0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, fifo_rd_en, out_valid, out_last} !== 5'b0 || out_data !== '0 || tile_idx !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b rd=%b v=%b l=%b d=%0d t=%0d required all 0",
                     busy, done, fifo_rd_en, out_valid, out_last, out_data, tile_idx);
        end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_basic();
        fifo_write(16);
        do_start(2);
        checks++;
        if (out_valid !== 1'b0 || fifo_rd_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_pop got v=%b rd=%b busy=%b required v=0 rd=1 busy=1",
                     out_valid, fifo_rd_en, busy);
        end
        wait_done(60, "basic");
        checks++;
        if (first_acc_cyc !== start_cyc + 2) begin
            failures++;
            $display("FAIL basic_latency got=%0d required=%0d", first_acc_cyc, start_cyc + 2);
        end
        checks++;
        if (run_accepts !== 16 || last_acc_cyc - first_acc_cyc !== 15) begin
            failures++;
            $display("FAIL basic_throughput got beats=%0d span=%0d required beats=16 span=15",
                     run_accepts, last_acc_cyc - first_acc_cyc);
        end
        checks++;
        if (done_cyc !== last_acc_cyc + 1) begin
            failures++;
            $display("FAIL basic_done_cyc got=%0d required=%0d", done_cyc, last_acc_cyc + 1);
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_ptr - rd_ptr !== 0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL basic_end got done=%b busy=%b fifo_left=%0d sb=%0d required 0 0 0 0",
                     done, busy, wr_ptr - rd_ptr, sb.size());
        end
    endtask

    task automatic test_backpressure();
        fifo_write(16);
        bp_mode = 1;
        do_start(2);
        wait_done(150, "backpressure");
        bp_mode = 0;
        out_ready = 1'b1;
        checks++;
        if (run_accepts !== 16 || sb.size() !== 0 || wr_ptr - rd_ptr !== 0) begin
            failures++;
            $display("FAIL bp_count got beats=%0d sb=%0d fifo_left=%0d required 16 0 0",
                     run_accepts, sb.size(), wr_ptr - rd_ptr);
        end
    endtask

    task automatic test_starvation();
        int written = 0;
        int k = 0;
        int d0 = done_cnt;
        model_stall = 0;
        do_start(2);
        while (done_cnt == d0 && k < 300) begin
            if (written < 16 && (k % 3) == 0) begin
                fifo_write(1);
                written++;
            end
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (done_cnt == d0 || run_accepts !== 16 || sb.size() !== 0) begin
            failures++;
            $display("FAIL starve_run got done_cnt=%0d beats=%0d sb=%0d required done, 16, 0",
                     done_cnt, run_accepts, sb.size());
        end
`ifdef BUFFER_READER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'(model_stall)) begin
            failures++;
            $display("FAIL stall_cnt got=%0d required=%0d", stall_cnt, model_stall);
        end
`else
        checks++;
        if (model_stall < 16) begin
            failures++;
            $display("FAIL starve_cycles got=%0d required>=16", model_stall);
        end
`endif
    endtask

    task automatic test_zero();
        int d0 = done_cnt;
        rd_seen = 0;
        do_start(0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_done got busy=%b done=%b required 1 1", busy, done);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_seen !== 1'b0 || done_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL zero_end got busy=%b done=%b rd_seen=%b pulses=%0d required 0 0 0 1",
                     busy, done, rd_seen, done_cnt - d0);
        end
    endtask

    task automatic test_overfull_restart();
        fifo_write(20);
        do_start(2);
        repeat (4) @(negedge clk);
        #1;
        start     = 1'b1;
        num_tiles = CW'(1);
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(60, "overfull");
        @(negedge clk); #1;
        checks++;
        if (wr_ptr - rd_ptr !== 4 || run_accepts !== 16 || sb.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overfull got fifo_left=%0d beats=%0d sb=%0d busy=%b required 4 16 0 0",
                     wr_ptr - rd_ptr, run_accepts, sb.size(), busy);
        end
        do_start(1);
        fifo_write(4);
        wait_done(60, "restart");
        checks++;
        if (run_accepts !== 8 || sb.size() !== 0 || wr_ptr - rd_ptr !== 0) begin
            failures++;
            $display("FAIL restart got beats=%0d sb=%0d fifo_left=%0d required 8 0 0",
                     run_accepts, sb.size(), wr_ptr - rd_ptr);
        end
    endtask

    task automatic test_reset_midrun();
        int k = 0;
        fifo_write(16);
        do_start(2);
        while (run_accepts < 4 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b1 || out_data !== DW'(exp_next - 16 + 4)) begin
            failures++;
            $display("FAIL fifth_beat got v=%b d=%0d required v=1 d=%0d", out_valid, out_data, exp_next - 12);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, fifo_rd_en, out_valid, out_last} !== 5'b0 || out_data !== '0 || tile_idx !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%b done=%b rd=%b v=%b l=%b d=%0d t=%0d required all 0",
                     busy, done, fifo_rd_en, out_valid, out_last, out_data, tile_idx);
        end
        repeat (2) @(negedge clk);
        #1;
        sb.delete();
        exp_next = rd_ptr + 1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got busy=%b v=%b required 0 0", busy, out_valid);
        end
        do_start(1);
        wait_done(60, "post_reset");
        checks++;
        if (run_accepts !== 8 || sb.size() !== 0) begin
            failures++;
            $display("FAIL post_reset_run got beats=%0d sb=%0d required 8 0", run_accepts, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_starvation();
        test_zero();
        test_overfull_restart();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
